mem_access_stage: RTL
=====================

// Module: mem_access_stage
// PURPOSE
// - EX->WB memory stage: registers EX results, issues aligned load/store requests to the data cache, extracts and extends load data.
// - Stalls the pipeline while a cache access is in flight; flags misaligned accesses and response timeouts.
// - Sits directly downstream of the execute stage, upstream of register writeback.
// PARAMETERS
// - XLEN          32   datapath/address width (only 32 supported)
// - RESP_TIMEOUT  255  max cycles waiting for DC_RESP_VALID before BUS_ERR (8-bit counter)
// PORTS
// - CLK            in   1   clock, all state on rising edge
// - RST            in   1   reset; asynchronous, active-high
// - EX_VALID       in   1   EX presents an instruction this cycle (already gated by EX flush)
// - EX_CTRL        in   2   00 none, 01 load, 10 store, 11 treated as none
// - EX_FUN3        in   3   000 B, 001 H, 010 W, 100 BU, 101 HU; others -> MISALIGN
// - EX_ADDR        in   32  effective address
// - EX_WB_DATA     in   32  ALU result for non-memory ops
// - EX_STORE_DATA  in   32  rs2 value for stores
// - EX_RD          in   5   destination register
// - DC_REQ_VALID   out  1   cache request valid
// - DC_REQ_READY   in   1   cache accepts request
// - DC_REQ_WRITE   out  1   1 store, 0 load
// - DC_ADDR        out  32  word-aligned address {EX_ADDR[31:2],2'b00}
// - DC_WDATA       out  32  store data replicated into lanes
// - DC_WSTRB       out  4   byte enables
// - DC_RESP_VALID  in   1   load data / store ack valid
// - DC_RDATA       in   32  read word
// - MEM_STALL      out  1   freeze EX and earlier stages
// - WB_VALID       out  1   WB_RD/WB_DATA valid (write if WB_RD!=0)
// - WB_RD          out  5   destination register
// - WB_DATA        out  32  writeback value
// - MISALIGN       out  1   1-cycle pulse: misaligned/illegal access, no cache request made
// - BUS_ERR        out  1   1-cycle pulse: response timeout
// - FAULT_ADDR     out  32  EX_ADDR of faulting access, held until next fault
// BEHAVIOUR
// - Reset: all outputs 0, FSM IDLE, timeout counter 0.
// - FSM IDLE: accepts EX when EX_VALID & !MEM_STALL.
//   - ctrl none: WB_VALID=1, WB_DATA=EX_WB_DATA next cycle (1-cycle latency), stay IDLE.
//   - load/store aligned: latch op, -> REQ same edge; MEM_STALL=1 from next cycle.
//   - misaligned (H: addr[0]!=0; W: addr[1:0]!=0) or illegal fun3: MISALIGN pulse, FAULT_ADDR latched, WB_VALID=0, stay IDLE.
// - REQ: DC_REQ_VALID=1, fields stable until DC_REQ_READY; on handshake -> WAIT. No timeout in REQ.
// - WAIT: DC_REQ_VALID=0; count cycles; on DC_RESP_VALID -> IDLE:
//   - load: WB_VALID=1, WB_DATA = lane selected by addr[1:0] (B/H) then sign-ext (B,H) or zero-ext (BU,HU); W passes word.
//   - store: WB_VALID=0.
//   - counter reaching RESP_TIMEOUT without response: BUS_ERR pulse, FAULT_ADDR latched, -> IDLE, no WB.
// - DC_RESP_VALID and timeout on same cycle: response wins.
// - MEM_STALL = (state!=IDLE); deasserts same cycle WB_VALID for the access is driven, so EX advances that edge.
// - Store lanes: B -> WDATA={4{d[7:0]}}, WSTRB=0001<<addr[1:0]; H -> {2{d[15:0]}}, 0011<<addr[1:0]; W -> d, 1111.
// - WB_VALID, MISALIGN, BUS_ERR are single-cycle pulses, low when no event.
// - RST mid-access: FSM to IDLE immediately, DC_REQ_VALID drops, outstanding response ignored.
// - Unexpected DC_RESP_VALID in IDLE/REQ: ignored.
// TESTING
// - ALU op EX_CTRL=00, EX_WB_DATA=0xDEADBEEF, EX_RD=5 -> next cycle WB_VALID=1, WB_RD=5, WB_DATA=0xDEADBEEF, no DC_REQ_VALID.
// - LB addr 0x1003, DC_RDATA=0x80FFFFFF, READY at once, resp 2 cycles later -> WB_DATA=0xFFFFFF80; LBU -> 0x00000080; MEM_STALL high 3 cycles.
// - SH addr 0x2002, data 0x0000ABCD, READY held low 3 cycles -> DC_REQ fields stable, DC_ADDR=0x2000, WDATA=0xABCDABCD, WSTRB=1100.
// - LW addr 0x3001 -> MISALIGN pulse, FAULT_ADDR=0x3001, no DC_REQ_VALID, no WB_VALID, MEM_STALL stays 0.
// - LW accepted, no response for RESP_TIMEOUT cycles -> BUS_ERR pulse, FSM IDLE, MEM_STALL 0, late response ignored.
// - Assert RST while in WAIT -> all outputs 0 asynchronously; following ALU op completes normally.

Source files
------------

// File: rtl/mem_access_stage.sv
// mem_access_stage: EX->WB memory stage of the pipeline.
//
// Registers the EX result, issues word-aligned load/store requests to the data
// cache, and extracts and extends the returned load data. The stage stalls
// upstream while an access is outstanding. It flags misaligned or illegal
// accesses (MISALIGN) and missing responses (BUS_ERR).
//
// Ports
//   CLK, RST                  clock; asynchronous active-high reset
//   EX_VALID/CTRL/FUN3/ADDR   instruction from EX (CTRL: 01 load, 10 store, else ALU)
//   EX_WB_DATA/STORE_DATA/RD  ALU result, store data, destination register
//   DC_REQ_*/DC_ADDR/WDATA/   data cache request channel (valid/ready handshake)
//   DC_WSTRB
//   DC_RESP_VALID/DC_RDATA    data cache response (load data or store ack)
//   MEM_STALL                 freeze EX and earlier stages
//   WB_VALID/WB_RD/WB_DATA    writeback pulse to the register file
//   MISALIGN/BUS_ERR          single-cycle fault pulses
//   FAULT_ADDR                address of the last faulting access
module mem_access_stage #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned RESP_TIMEOUT = 255
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            EX_VALID,
  input  logic [1:0]      EX_CTRL,
  input  logic [2:0]      EX_FUN3,
  input  logic [XLEN-1:0] EX_ADDR,
  input  logic [XLEN-1:0] EX_WB_DATA,
  input  logic [XLEN-1:0] EX_STORE_DATA,
  input  logic [4:0]      EX_RD,
  output logic            DC_REQ_VALID,
  input  logic            DC_REQ_READY,
  output logic            DC_REQ_WRITE,
  output logic [XLEN-1:0] DC_ADDR,
  output logic [XLEN-1:0] DC_WDATA,
  output logic [3:0]      DC_WSTRB,
  input  logic            DC_RESP_VALID,
  input  logic [XLEN-1:0] DC_RDATA,
  output logic            MEM_STALL,
  output logic            WB_VALID,
  output logic [4:0]      WB_RD,
  output logic [XLEN-1:0] WB_DATA,
  output logic            MISALIGN,
  output logic            BUS_ERR,
  output logic [XLEN-1:0] FAULT_ADDR
);

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  localparam logic [1:0] CtrlLoad  = 2'b01;
  localparam logic [1:0] CtrlStore = 2'b10;
  // Timeout fires on the cycle the counter would reach RESP_TIMEOUT.
  localparam logic [7:0] TimeoutCnt = 8'(RESP_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              op_store_q, op_store_d;
  logic [2:0]        op_fun3_q, op_fun3_d;
  logic [XLEN-1:0]   op_addr_q, op_addr_d;
  logic [4:0]        op_rd_q, op_rd_d;
  logic [XLEN-1:0]   op_wdata_q, op_wdata_d;
  logic [3:0]        op_wstrb_q, op_wstrb_d;
  logic              wb_valid_q, wb_valid_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]   wb_data_q, wb_data_d;
  logic              misalign_q, misalign_d;
  logic              bus_err_q, bus_err_d;
  logic [XLEN-1:0]   fault_addr_q, fault_addr_d;

  logic              is_mem;
  logic              access_ok;
  logic [XLEN-1:0]   st_wdata;
  logic [3:0]        st_wstrb;
  logic [XLEN-1:0]   rd_shifted;
  logic [XLEN-1:0]   ld_data;

  // Alignment/legality check and store lane placement, from the EX inputs.
  always_comb begin
    is_mem    = (EX_CTRL == CtrlLoad) || (EX_CTRL == CtrlStore);
    access_ok = 1'b0;
    st_wdata  = EX_STORE_DATA;
    st_wstrb  = 4'b1111;
    case (EX_FUN3)
      3'b000, 3'b100: begin
        access_ok = 1'b1;
        st_wdata  = {4{EX_STORE_DATA[7:0]}};
        st_wstrb  = 4'b0001 << EX_ADDR[1:0];
      end
      3'b001, 3'b101: begin
        access_ok = ~EX_ADDR[0];
        st_wdata  = {2{EX_STORE_DATA[15:0]}};
        st_wstrb  = 4'b0011 << EX_ADDR[1:0];
      end
      3'b010: begin
        access_ok = (EX_ADDR[1:0] == 2'b00);
      end
      default: access_ok = 1'b0;
    endcase
  end

  // Load lane extraction; W accesses are aligned so the shift is zero.
  always_comb begin
    rd_shifted = DC_RDATA >> {op_addr_q[1:0], 3'b000};
    case (op_fun3_q)
      3'b000:  ld_data = {{24{rd_shifted[7]}}, rd_shifted[7:0]};
      3'b100:  ld_data = {24'd0, rd_shifted[7:0]};
      3'b001:  ld_data = {{16{rd_shifted[15]}}, rd_shifted[15:0]};
      3'b101:  ld_data = {16'd0, rd_shifted[15:0]};
      default: ld_data = rd_shifted;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_store_d   = op_store_q;
    op_fun3_d    = op_fun3_q;
    op_addr_d    = op_addr_q;
    op_rd_d      = op_rd_q;
    op_wdata_d   = op_wdata_q;
    op_wstrb_d   = op_wstrb_q;
    wb_valid_d   = 1'b0;
    wb_rd_d      = wb_rd_q;
    wb_data_d    = wb_data_q;
    misalign_d   = 1'b0;
    bus_err_d    = 1'b0;
    fault_addr_d = fault_addr_q;

    unique case (state_q)
      StIdle: begin
        if (EX_VALID) begin
          if (is_mem && access_ok) begin
            op_store_d = (EX_CTRL == CtrlStore);
            op_fun3_d  = EX_FUN3;
            op_addr_d  = EX_ADDR;
            op_rd_d    = EX_RD;
            op_wdata_d = st_wdata;
            op_wstrb_d = st_wstrb;
            state_d    = StReq;
          end else if (is_mem) begin
            misalign_d   = 1'b1;
            fault_addr_d = EX_ADDR;
          end else begin
            wb_valid_d = 1'b1;
            wb_rd_d    = EX_RD;
            wb_data_d  = EX_WB_DATA;
          end
        end
      end
      StReq: begin
        if (DC_REQ_READY) begin
          state_d = StWait;
          cnt_d   = 8'd0;
        end
      end
      StWait: begin
        // A response on the timeout cycle still completes normally.
        if (DC_RESP_VALID) begin
          state_d = StIdle;
          if (!op_store_q) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = op_rd_q;
            wb_data_d  = ld_data;
          end
        end else if (cnt_q == TimeoutCnt) begin
          state_d      = StIdle;
          bus_err_d    = 1'b1;
          fault_addr_d = op_addr_q;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      op_store_q   <= 1'b0;
      op_fun3_q    <= '0;
      op_addr_q    <= '0;
      op_rd_q      <= '0;
      op_wdata_q   <= '0;
      op_wstrb_q   <= '0;
      wb_valid_q   <= 1'b0;
      wb_rd_q      <= '0;
      wb_data_q    <= '0;
      misalign_q   <= 1'b0;
      bus_err_q    <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_store_q   <= op_store_d;
      op_fun3_q    <= op_fun3_d;
      op_addr_q    <= op_addr_d;
      op_rd_q      <= op_rd_d;
      op_wdata_q   <= op_wdata_d;
      op_wstrb_q   <= op_wstrb_d;
      wb_valid_q   <= wb_valid_d;
      wb_rd_q      <= wb_rd_d;
      wb_data_q    <= wb_data_d;
      misalign_q   <= misalign_d;
      bus_err_q    <= bus_err_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  // Request fields are driven only while a request is presented.
  assign DC_REQ_VALID = (state_q == StReq);
  assign DC_REQ_WRITE = DC_REQ_VALID & op_store_q;
  assign DC_ADDR      = DC_REQ_VALID ? {op_addr_q[XLEN-1:2], 2'b00} : '0;
  assign DC_WDATA     = DC_REQ_WRITE ? op_wdata_q : '0;
  assign DC_WSTRB     = DC_REQ_WRITE ? op_wstrb_q : '0;
  assign MEM_STALL    = (state_q != StIdle);
  assign WB_VALID     = wb_valid_q;
  assign WB_RD        = wb_rd_q;
  assign WB_DATA      = wb_data_q;
  assign MISALIGN     = misalign_q;
  assign BUS_ERR      = bus_err_q;
  assign FAULT_ADDR   = fault_addr_q;

endmodule
